// File: rtl/fp_accum_seq.sv
// fp_accum_seq: accumulates groups of IEEE-754 single operands into a running
// sum with one combinational adder between the accumulator and an operand
// register. Each group, terminated by in_last, produces a single result record
// (sum, saturating operand count, overflow flag) that is held until it is taken.
//
// Handshake semantics: a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready are both 1; a producer holds its
// payload stable while valid is high and ready is low, and ready never depends
// combinationally on valid (in_ready and out_valid decode only state and rst).

module fp_accum_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_acc;
    logic [31:0]      r_op;
    logic             r_pend;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [31:0]      w_add;
    logic             w_accept;
    logic             w_add_ovf;
    logic             w_cnt_full;

    // The single adder: accumulator plus the operand captured last cycle.
    fpadder u_fpadder (
        .src1 (r_acc),
        .src2 (r_op),
        .out  (w_add)
    );

    assign w_accept   = in_valid && r_in_ready;
    assign w_add_ovf  = (w_add[30:23] == 8'hFF);
    assign w_cnt_full = (r_count == {CNT_W{1'b1}});

    // Sequencer: operand capture, pending add retirement, group handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_acc       <= 32'h0;
            r_op        <= 32'h0;
            r_pend      <= 1'b0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            // A captured operand is folded in exactly one cycle after capture.
            if (r_pend) begin
                r_acc <= w_add;
                r_ovf <= r_ovf | w_add_ovf;
            end
            if (w_accept) begin
                r_op    <= in_data;
                r_count <= r_count + {{(CNT_W-1){1'b0}}, !w_cnt_full};
            end
            // Stays set across back-to-back accepts so no operand is skipped.
            r_pend <= w_accept;

            case (r_state)
                ST_ACC: begin
                    if (w_accept && in_last) begin
                        r_state    <= ST_DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The last operand's add retires this cycle.
                    r_state     <= ST_OUT;
                    r_out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_acc       <= 32'h0;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= ST_ACC;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACC;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Reset masks both flow-control outputs in the same cycle it is applied.
    assign in_ready    = r_in_ready && !rst;
    assign out_valid   = r_out_valid && !rst;
    assign out_data    = r_acc;
    assign out_count   = r_count;
    assign out_ovf     = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// fpadder: combinational IEEE-754 single-precision add, round to nearest even.
// Subnormal inputs and results are flushed to +0; exact cancellation gives +0;
// a result whose exponent reaches 255 becomes a correctly signed infinity.
module fpadder (
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] out
);

    logic              w_swap;
    logic [31:0]       w_big;
    logic [31:0]       w_sml;
    logic [7:0]        w_el;
    logic [7:0]        w_es;
    logic [23:0]       w_ml;
    logic [23:0]       w_ms;
    logic [7:0]        w_ediff;
    logic [4:0]        w_sh;
    logic [58:0]       w_wide;
    logic [26:0]       w_align;
    logic [27:0]       w_sum;
    logic [4:0]        w_lz;
    logic [26:0]       w_norm;
    logic signed [9:0] w_exp;
    logic              w_rnd_up;
    logic [24:0]       w_mant;
    logic signed [9:0] w_exp_f;
    logic [22:0]       w_frac;
    logic              w_a_spec;
    logic              w_b_spec;

    // Index of the leading one counted from bit 26 (27 when v is zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // Align, add/subtract, normalise, round, then pack with special cases.
    always_comb begin
        w_swap  = (src2[30:0] > src1[30:0]);
        w_big   = w_swap ? src2 : src1;
        w_sml   = w_swap ? src1 : src2;
        w_el    = w_big[30:23];
        w_es    = w_sml[30:23];
        w_ml    = (w_el == 8'd0) ? 24'd0 : {1'b1, w_big[22:0]};
        w_ms    = (w_es == 8'd0) ? 24'd0 : {1'b1, w_sml[22:0]};
        w_ediff = w_el - w_es;
        w_sh    = (w_ediff > 8'd31) ? 5'd31 : w_ediff[4:0];

        // Smaller mantissa gets guard/round bits above the point and 32 bits
        // below that collapse into a sticky bit.
        w_wide  = {w_ms, 35'd0} >> w_sh;
        w_align = w_wide[58:32] | {26'd0, |w_wide[31:0]};

        if (w_big[31] == w_sml[31]) begin
            w_sum = {1'b0, w_ml, 3'b000} + {1'b0, w_align};
        end else begin
            w_sum = {1'b0, w_ml, 3'b000} - {1'b0, w_align};
        end

        w_lz = 5'd0;
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], |w_sum[1:0]};
            w_exp  = $signed({2'b00, w_el}) + 10'sd1;
        end else begin
            w_lz   = lzc27(w_sum[26:0]);
            w_norm = w_sum[26:0] << w_lz;
            w_exp  = $signed({2'b00, w_el}) - $signed({5'd0, w_lz});
        end

        w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mant   = {1'b0, w_norm[26:3]} + {24'd0, w_rnd_up};
        w_exp_f  = w_mant[24] ? (w_exp + 10'sd1) : w_exp;
        w_frac   = w_mant[24] ? w_mant[23:1] : w_mant[22:0];

        w_a_spec = &src1[30:23];
        w_b_spec = &src2[30:23];

        if (w_a_spec && w_b_spec && (src1[31] != src2[31])) begin
            out = 32'h7FC00000;
        end else if (w_a_spec) begin
            out = src1;
        end else if (w_b_spec) begin
            out = src2;
        end else if (w_sum == 28'd0) begin
            out = 32'h0;
        end else if (w_exp_f >= 10'sd255) begin
            out = {w_big[31], 8'hFF, 23'd0};
        end else if (w_exp_f <= 10'sd0) begin
            out = 32'h0;
        end else begin
            out = {w_big[31], w_exp_f[7:0], w_frac};
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: directed vector table, hand-written multi-cycle
// sequences (backpressure, resets mid-group and in OUT, count saturation) and
// randomized groups checked against a real-arithmetic reference model.

module tb_fp_accum_seq;

    localparam int CNT_W = 4;
    localparam int EW    = 32 + CNT_W + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = 32'h0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic [1:0]       dbg_state;

    fp_accum_seq #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_ovf     (out_ovf),
        .out_ready   (out_ready),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [EW-1:0] exp_q[$];
    logic rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Random downstream readiness while enabled.
    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Result monitor: handshake compare, hold stability, single-cycle valid.
    logic          hold_v = 1'b0;
    logic [EW-1:0] hold_val;
    logic          hs_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            hold_v  = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) chk("valid_drop_after_handshake", 64'(out_valid), 64'd0);
            if (hold_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_result", 64'({out_data, out_count, out_ovf}), 64'(hold_val));
            end
            hs_prev = out_valid && out_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_result: got %h, required no result (cycle %0d)",
                             {out_data, out_count, out_ovf}, cyc);
                end else begin
                    chk("result", 64'({out_data, out_count, out_ovf}), 64'(exp_q.pop_front()));
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_val = {out_data, out_count, out_ovf};
        end
    end

    // ---------------- reference model ----------------
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real    a, f, rem;
        int     e;
        longint mi;
        logic   s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        f   = a * 8388608.0;
        mi  = longint'($floor(f));
        rem = f - real'(mi);
        if (rem > 0.5 || (rem == 0.5 && mi[0])) mi++;
        if (mi == 64'd16777216) begin mi = 64'd8388608; e++; end
        if (e > 127) return {s, 8'hFF, 23'h0};
        if (e < -126) return 32'h0;
        return {s, 8'(e + 127), mi[22:0]};
    endfunction

    // Sum, saturating count and overflow flag of one group.
    function automatic logic [EW-1:0] model_group(input logic [31:0] ops[$]);
        logic [31:0] acc = 32'h0;
        logic        ovf = 1'b0;
        int          n   = ops.size();
        foreach (ops[i]) begin
            acc = r2f(f2r(acc) + f2r(ops[i]));
            ovf = ovf | (acc[30:23] == 8'hFF);
        end
        if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
        return {acc, CNT_W'(n), ovf};
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    // Presents one operand until accepted; e returns the accepting edge count.
    task automatic send_op(input logic [31:0] d, input logic l, output int e);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && k < 300) begin @(negedge clk); k++; end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL accept_timeout: got in_ready=0, required 1 (cycle %0d)", cyc);
        end
        @(posedge clk); #1;
        e        = cyc;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin @(negedge clk); k++; end
        chk(name, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin @(negedge clk); k++; end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int               n;
        logic [31:0]      ops[4];
        logic [31:0]      exp_data;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_ovf;
    } vec_t;

    vec_t vt[8];

    task automatic set_vec(input int i, input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [31:0] sum,
                           input logic [CNT_W-1:0] cnt, input logic ovf);
        vt[i].n = n;
        vt[i].ops[0] = a; vt[i].ops[1] = b; vt[i].ops[2] = c; vt[i].ops[3] = d;
        vt[i].exp_data = sum;
        vt[i].exp_cnt  = cnt;
        vt[i].exp_ovf  = ovf;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          e;
        logic [31:0] ops[$];
        logic [31:0] op;
        int          n;

        // 1+2+0.5 = 3.5
        set_vec(0, 3, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h0, 32'h40600000, 4'd3, 1'b0);
        set_vec(1, 1, 32'hC0400000, 32'h0, 32'h0, 32'h0, 32'hC0400000, 4'd1, 1'b0);
        // exact cancellation
        set_vec(2, 2, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 32'h00000000, 4'd2, 1'b0);
        // 2^127 + 2^127 overflows to +inf
        set_vec(3, 2, 32'h7F000000, 32'h7F000000, 32'h0, 32'h0, 32'h7F800000, 4'd2, 1'b1);
        // the group after an overflow starts clean
        set_vec(4, 1, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h3F800000, 4'd1, 1'b0);
        // 3 + 1.5 - 5 + 0.25 = -0.25
        set_vec(5, 4, 32'h40400000, 32'h3FC00000, 32'hC0A00000, 32'h3E800000, 32'hBE800000, 4'd4, 1'b0);
        // 2^24 + 1 ties to even (2^24), then +2 is exact
        set_vec(6, 3, 32'h4B800000, 32'h3F800000, 32'h40000000, 32'h0, 32'h4B800001, 4'd3, 1'b0);
        // (2^24+2) + 1 ties up to the even neighbour 2^24+4
        set_vec(7, 2, 32'h4B800001, 32'h3F800000, 32'h0, 32'h0, 32'h4B800002, 4'd2, 1'b0);

        @(posedge clk); #1;
        do_reset();
        chk("reset_count", 64'(out_count), 64'd0);
        chk("reset_ovf", 64'(out_ovf), 64'd0);
        chk("reset_acc", 64'(out_data), 64'd0);

        // Directed table, back-to-back operands, downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vt[i].exp_data, vt[i].exp_cnt, vt[i].exp_ovf});
            for (int j = 0; j < vt[i].n; j++) send_op(vt[i].ops[j], (j == vt[i].n - 1), e);
            // The last accept is at edge e; its cycle began at edge e-1.
            @(negedge clk);
            chk("drain_no_valid", 64'(out_valid), 64'd0);
            chk("drain_in_ready", 64'(in_ready), 64'd0);
            wait_valid("group_valid");
            chk("latency_cycles", 64'(cyc - (e - 1)), 64'd2);
            @(posedge clk); #1;
        end
        wait_drain();

        // Count saturates at 2^CNT_W-1; sum is still exact (20.0).
        exp_q.push_back({32'h41A00000, 4'hF, 1'b0});
        for (int j = 0; j < 20; j++) send_op(32'h3F800000, (j == 19), e);
        wait_drain();

        // Backpressure with junk operands offered while not ready.
        out_ready = 1'b0;
        exp_q.push_back({32'h40400000, 4'd2, 1'b0});
        send_op(32'h3FC00000, 1'b0, e);
        send_op(32'h3FC00000, 1'b1, e);
        in_valid = 1'b1; in_data = 32'h42000000; in_last = 1'b1;
        wait_valid("bp_valid");
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        wait_drain();

        // Reset one cycle after a non-last accept discards the partial group.
        send_op(32'h40000000, 1'b0, e);
        rst = 1'b1;
        @(negedge clk);
        chk("midgroup_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back({32'h3F800000, 4'd1, 1'b0});
        send_op(32'h3F800000, 1'b1, e);
        wait_drain();

        // Reset while a result waits in OUT: no result ever appears.
        out_ready = 1'b0;
        send_op(32'h40400000, 1'b1, e);
        wait_valid("abort_valid");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_result", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Randomized groups with idle gaps and random downstream readiness.
        rnd_ready = 1'b1;
        for (int g = 0; g < 40; g++) begin
            n = $urandom_range(1, 6);
            ops.delete();
            for (int j = 0; j < n; j++) begin
                op = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
                ops.push_back(op);
            end
            exp_q.push_back(model_group(ops));
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send_op(ops[j], (j == n - 1), e);
            end
        end
        wait_drain();
        @(negedge clk);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fp_accum_seq.md
FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, element-counter width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, upstream operand valid.
REQ-005 SHALL have port in_data, input, 32, IEEE-754 single operand.
REQ-006 SHALL have port in_last, input, 1, marks final operand of a group; qualified by in_valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-008 SHALL have port out_valid, output, 1, group sum valid.
REQ-009 SHALL have port out_data, output, 32, group sum in IEEE-754 single format.
REQ-010 SHALL have port out_count, output, CNT_W, operands in group, saturating.
REQ-011 SHALL have port out_ovf, output, 1, some partial sum reached exponent 8'hFF.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.

Function
REQ-013 SHALL instantiate one combinational fpadder, with src1 = accumulator and src2 = operand register; its out is the next accumulator value.
REQ-014 SHALL implement FSM states ACC, DRAIN, OUT.
REQ-015 In ACC: in_ready = 1. In DRAIN and OUT: in_ready = 0.
REQ-016 Accept = in_valid && in_ready: op_reg <= in_data, op_pend <= 1, count <= count+1 (saturating at 2^CNT_W-1).
REQ-017 Each cycle op_pend = 1: acc <= fpadder.out; out_ovf <= out_ovf | (fpadder.out[30:23] == 8'hFF); op_pend clears unless a new accept occurs the same cycle.
REQ-018 Back-to-back accepts in ACC SHALL sustain one operand per cycle, with no lost operand.
REQ-019 Accept with in_last = 1: ACC -> DRAIN.
REQ-020 DRAIN: the pending add completes, then DRAIN -> OUT unconditionally after one cycle.
REQ-021 Latency: last operand accepted in cycle T -> out_valid = 1 in cycle T+2.
REQ-022 OUT: out_valid = 1; out_data = acc, out_count = count, and out_ovf SHALL all hold stable until handshake.
REQ-023 OUT with out_ready = 1: acc <= 32'h0, count <= 0, out_ovf <= 0, state -> ACC.
REQ-023a out_valid SHALL drop the cycle after the OUT handshake; the first new operand can be accepted that cycle.
REQ-024 out_valid = 0 in ACC and DRAIN; out_data is don't-care there but SHALL equal acc.
REQ-025 Accumulator initial value SHALL be +0.0 (32'h00000000).
REQ-026 Exact cancellation to zero SHALL yield 32'h00000000, per fpadder behaviour.
REQ-027 out_ready asserted outside OUT SHALL be ignored.
REQ-028 A group always contains at least one operand; there is no empty-group case.
REQ-029 in_data and in_last SHALL be ignored when in_ready = 0.

Reset
REQ-030 rst = 1 at a clock edge: state = ACC, acc = 32'h0, op_reg = 32'h0, op_pend = 0, count = 0, out_ovf = 0.
REQ-031 Outputs during and after reset: in_ready = 0 while rst = 1; out_valid = 0; in_ready = 1 the first cycle after rst deasserts.
REQ-032 Reset in any state (including a pending add or OUT awaiting out_ready) SHALL discard all partial results; no out_valid is produced for the aborted group.

Verification
REQ-033 Stream: 3F800000, 40000000, 3F000000 (last) on consecutive cycles, out_ready = 1 -> out_data = 40600000, out_count = 3, out_ovf = 0, out_valid exactly 2 cycles after the last accept, for one cycle.
REQ-034 Single operand C0400000 with in_last = 1 -> out_data = C0400000, out_count = 1.
REQ-035 Stream: 3F800000, BF800000 (last) -> out_data = 00000000, out_count = 2.
REQ-036 Stream: 7F000000, 7F000000 (last) -> out_data = 7F800000, out_ovf = 1; the next group 3F800000 (last) -> out_ovf = 0, out_data = 3F800000.
REQ-037 Backpressure: out_ready = 0 for 5 cycles in OUT -> out_valid held and out_data/out_count stable, with in_ready = 0 throughout; out_ready = 1 -> next cycle in_ready = 1, out_valid = 0.
REQ-038 rst pulsed one cycle after accepting 40000000 (no last) -> a subsequent 3F800000 (last) yields out_data = 3F800000, out_count = 1.
